// File: rtl/video_overlay_pkg.sv
// ---------------------------------------------------------------------------
// video_overlay_pkg
// Shared types and helpers for the video overlay mux:
//   mode_t      - background selection mode (camera / gray / b&w / overlay)
//   sideband_t  - timing bundle that travels alongside each pixel
//   luma_f      - (R + 2G + B) >> 2 with enough headroom to never overflow
// ---------------------------------------------------------------------------
package video_overlay_pkg;

  localparam int DEF_COLOR_W = 8;
  // Widest channel the luma helper accepts; callers zero-extend into it.
  localparam int LUMA_MAX_W  = 16;

  typedef enum logic [1:0] {
    MODE_CAMERA  = 2'b00,
    MODE_GRAY    = 2'b01,
    MODE_BW      = 2'b10,
    MODE_OVERLAY = 2'b11
  } mode_t;

  typedef struct packed {
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [10:0] hcount;
    logic [9:0]  vcount;
  } sideband_t;

  // Sum is formed two bits wider than a channel so 255+510+255 cannot wrap.
  function automatic logic [LUMA_MAX_W-1:0] luma_f(
    input logic [LUMA_MAX_W-1:0] r,
    input logic [LUMA_MAX_W-1:0] g,
    input logic [LUMA_MAX_W-1:0] b
  );
    logic [LUMA_MAX_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[LUMA_MAX_W+1:2];
  endfunction

endpackage

// File: rtl/video_overlay_if.sv
// ---------------------------------------------------------------------------
// video_overlay_if
// Pixel stream, configuration and output bundle of video_overlay_mux.
//   slave  modport : the mux (consumes *_in, drives *_out)
//   master modport : the upstream/downstream side (drives *_in, sees *_out)
// ---------------------------------------------------------------------------
interface video_overlay_if #(
  parameter int PIXEL_W   = 24,
  parameter int NUM_MASKS = 2,
  parameter int IDX_W     = 1
);
  logic                 valid_in;
  logic [10:0]          hcount_in;
  logic [9:0]           vcount_in;
  logic                 hsync_in;
  logic                 vsync_in;
  logic                 active_in;
  logic [PIXEL_W-1:0]   camera_pixel_in;
  logic [NUM_MASKS-1:0] mask_in;
  logic [1:0]           mode_in;
  logic [IDX_W-1:0]     mask_sel_in;
  logic [10:0]          cross_x_in;
  logic [9:0]           cross_y_in;
  logic                 cfg_we_in;
  logic [IDX_W-1:0]     cfg_idx_in;
  logic [PIXEL_W-1:0]   cfg_color_in;

  logic [PIXEL_W-1:0]   pixel_out;
  logic                 valid_out;
  logic                 hsync_out;
  logic                 vsync_out;
  logic                 active_out;
  logic [10:0]          hcount_out;
  logic [9:0]           vcount_out;

  modport slave (
    input  valid_in, hcount_in, vcount_in, hsync_in, vsync_in, active_in,
           camera_pixel_in, mask_in, mode_in, mask_sel_in, cross_x_in,
           cross_y_in, cfg_we_in, cfg_idx_in, cfg_color_in,
    output pixel_out, valid_out, hsync_out, vsync_out, active_out,
           hcount_out, vcount_out
  );

  modport master (
    output valid_in, hcount_in, vcount_in, hsync_in, vsync_in, active_in,
           camera_pixel_in, mask_in, mode_in, mask_sel_in, cross_x_in,
           cross_y_in, cfg_we_in, cfg_idx_in, cfg_color_in,
    input  pixel_out, valid_out, hsync_out, vsync_out, active_out,
           hcount_out, vcount_out
  );
endinterface

// File: rtl/video_sideband_delay.sv
// ---------------------------------------------------------------------------
// video_sideband_delay
// Generic N-stage, W-bit shift register with synchronous active-high reset.
//   clk_i, rst_i : clock, synchronous reset (clears every stage)
//   d_i          : value entering the delay line
//   q_o          : d_i delayed by N cycles
// ---------------------------------------------------------------------------
module video_sideband_delay #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [N];

  // NOTE: state is updated with non-blocking assignments so every stage
  // shifts from the values present before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[N-1];
endmodule

// File: rtl/video_overlay_mux.sv
// ---------------------------------------------------------------------------
// video_overlay_mux
// Two-stage display mux between camera/threshold pipeline and TMDS encode.
//   clk_in, rst_in : pixel clock, synchronous active-high reset
//   vid (slave)    : pixel stream in, mask bits, mode/colour configuration,
//                    registered pixel + sideband out (latency 2)
// Stage 1 builds the background (camera, gray, b/w mask, colour overlay),
// stage 2 applies the optional crosshair and blanking. Mode, mask select,
// crosshair and mask colours are staged in "pending" registers and copied
// to the "active" set on the frame-start pixel, which already uses them.
// Optional feature macro: VIDEO_OVERLAY_CROSSHAIR_EN (crosshair overlay).
// ---------------------------------------------------------------------------
module video_overlay_mux
  import video_overlay_pkg::*;
#(
  parameter int          COLOR_W     = DEF_COLOR_W,
  parameter int          NUM_MASKS   = 2,
  parameter logic [23:0] MASK_RST    = 24'hFF77AA,
  parameter logic [23:0] CROSS_COLOR = 24'h00FF00
) (
  input  logic     clk_in,
  input  logic     rst_in,
  video_overlay_if.slave vid
);
  localparam int PIXEL_W = 3 * COLOR_W;
  localparam int IDX_W   = (NUM_MASKS > 1) ? $clog2(NUM_MASKS) : 1;
  localparam logic [PIXEL_W-1:0] MASK_RST_PX = PIXEL_W'(MASK_RST);

  typedef logic [PIXEL_W-1:0] pixel_t;

  logic frame_start;
  assign frame_start = vid.valid_in & vid.active_in &
                       (vid.hcount_in == 11'd0) & (vid.vcount_in == 10'd0);

  // ---------------- pending / active configuration ----------------
  mode_t            pend_mode_q, act_mode_q, eff_mode;
  logic [IDX_W-1:0] pend_sel_q,  act_sel_q,  eff_sel, bw_idx;
  pixel_t           pend_color_q [NUM_MASKS];
  pixel_t           pend_color_d [NUM_MASKS];
  pixel_t           act_color_q  [NUM_MASKS];
  pixel_t           eff_color    [NUM_MASKS];

  // A colour write in the frame-start cycle lands in the new active set.
  always_comb begin
    for (int i = 0; i < NUM_MASKS; i++) begin
      pend_color_d[i] = (vid.cfg_we_in && (int'(vid.cfg_idx_in) == i)) ?
                        vid.cfg_color_in : pend_color_q[i];
      eff_color[i]    = frame_start ? pend_color_d[i] : act_color_q[i];
    end
  end

  assign eff_mode = frame_start ? pend_mode_q : act_mode_q;
  assign eff_sel  = frame_start ? pend_sel_q  : act_sel_q;
  assign bw_idx   = (int'(eff_sel) < NUM_MASKS) ? eff_sel : '0;

  // NOTE: the colour tables are a handful of flops, not a RAM, so they are
  // reset to the defaults like any other state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_mode_q <= MODE_CAMERA;
      act_mode_q  <= MODE_CAMERA;
      pend_sel_q  <= '0;
      act_sel_q   <= '0;
      for (int i = 0; i < NUM_MASKS; i++) begin
        pend_color_q[i] <= MASK_RST_PX;
        act_color_q[i]  <= MASK_RST_PX;
      end
    end else begin
      pend_mode_q <= mode_t'(vid.mode_in);
      pend_sel_q  <= vid.mask_sel_in;
      act_mode_q  <= eff_mode;
      act_sel_q   <= eff_sel;
      for (int i = 0; i < NUM_MASKS; i++) begin
        pend_color_q[i] <= pend_color_d[i];
        act_color_q[i]  <= eff_color[i];
      end
    end
  end

  // ---------------- stage 1: background ----------------
  logic [COLOR_W-1:0] luma;
  pixel_t             bg, s1_pix_q;

  assign luma = COLOR_W'(luma_f(
      LUMA_MAX_W'(vid.camera_pixel_in[PIXEL_W-1 -: COLOR_W]),
      LUMA_MAX_W'(vid.camera_pixel_in[2*COLOR_W-1 -: COLOR_W]),
      LUMA_MAX_W'(vid.camera_pixel_in[COLOR_W-1:0])));

  // NOTE: bg gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    bg = vid.camera_pixel_in;
    case (eff_mode)
      MODE_GRAY: bg = {3{luma}};
      MODE_BW:   bg = vid.mask_in[bw_idx] ? '1 : '0;
      MODE_OVERLAY: begin
        // Walk downwards so the lowest set channel is the last writer.
        for (int i = NUM_MASKS - 1; i >= 0; i--) begin
          if (vid.mask_in[i]) bg = eff_color[i];
        end
      end
      default: bg = vid.camera_pixel_in;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) s1_pix_q <= '0;
    else        s1_pix_q <= (vid.valid_in & vid.active_in) ? bg : '0;
  end

`ifdef VIDEO_OVERLAY_CROSSHAIR_EN
  localparam logic [PIXEL_W-1:0] CROSS_PX = PIXEL_W'(CROSS_COLOR);

  logic [10:0] pend_cx_q, act_cx_q, eff_cx;
  logic [9:0]  pend_cy_q, act_cy_q, eff_cy;
  logic        s1_cross_q;

  assign eff_cx = frame_start ? pend_cx_q : act_cx_q;
  assign eff_cy = frame_start ? pend_cy_q : act_cy_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_cx_q  <= '0;
      pend_cy_q  <= '0;
      act_cx_q   <= '0;
      act_cy_q   <= '0;
      s1_cross_q <= 1'b0;
    end else begin
      pend_cx_q  <= vid.cross_x_in;
      pend_cy_q  <= vid.cross_y_in;
      act_cx_q   <= eff_cx;
      act_cy_q   <= eff_cy;
      s1_cross_q <= vid.valid_in & ((vid.hcount_in == eff_cx) |
                                    (vid.vcount_in == eff_cy));
    end
  end
`endif

  // ---------------- sideband: two 1-cycle hops ----------------
  sideband_t sb_in, sb_s1, sb_out;

  assign sb_in = '{valid:  vid.valid_in,  hsync:  vid.hsync_in,
                   vsync:  vid.vsync_in,  active: vid.active_in,
                   hcount: vid.hcount_in, vcount: vid.vcount_in};

  video_sideband_delay #(.N(1), .W($bits(sideband_t))) u_sb_s1 (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (sb_in),
    .q_o   (sb_s1)
  );

  video_sideband_delay #(.N(1), .W($bits(sideband_t))) u_sb_s2 (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (sb_s1),
    .q_o   (sb_out)
  );

  // ---------------- stage 2: crosshair + blanking ----------------
  pixel_t pixel_d, pixel_q;

  always_comb begin
    pixel_d = '0;
    if (sb_s1.active) begin
      pixel_d = s1_pix_q;
`ifdef VIDEO_OVERLAY_CROSSHAIR_EN
      if (s1_cross_q) pixel_d = CROSS_PX;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) pixel_q <= '0;
    else        pixel_q <= pixel_d;
  end

  assign vid.pixel_out  = pixel_q;
  assign vid.valid_out  = sb_out.valid;
  assign vid.hsync_out  = sb_out.hsync;
  assign vid.vsync_out  = sb_out.vsync;
  assign vid.active_out = sb_out.active;
  assign vid.hcount_out = sb_out.hcount;
  assign vid.vcount_out = sb_out.vcount;
endmodule
